// File: rtl/dec_ram_pkg.sv
// Shared constants and helpers for the decision-bit ping-pong frame buffer.
package dec_ram_pkg;

    localparam int MAX_BANKS  = 16;
    localparam int MAX_DATA_W = 64;

    function automatic int bank_idx_w(input int n);
        return $clog2(n);
    endfunction

    // Even parity: the returned bit makes the total number of ones even.
    function automatic logic parity(input logic [MAX_DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/dec_ram_pingpong_if.sv
// Decoder-side write bus, output-stage read bus and status of the frame buffer.
// DEC_RAM_PARITY_EN adds rd_parity_err.
interface dec_ram_pingpong_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_BANKS  = 2
);
    localparam int BW = dec_ram_pkg::bank_idx_w(NUM_BANKS);
    localparam int CW = $clog2(NUM_BANKS + 1);

    logic                  wr_valid;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_ready;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_done;
    logic                  rd_frame_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_data_valid;
    logic [BW-1:0]         wr_bank;
    logic [BW-1:0]         rd_bank;
    logic [CW-1:0]         frame_count;
    logic                  wr_overflow;
`ifdef DEC_RAM_PARITY_EN
    logic                  rd_parity_err;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
        input  wr_ready, rd_frame_valid, rd_data, rd_data_valid,
               wr_bank, rd_bank, frame_count, wr_overflow, rd_parity_err
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
        output wr_ready, rd_frame_valid, rd_data, rd_data_valid,
               wr_bank, rd_bank, frame_count, wr_overflow, rd_parity_err
    );
`else
    modport master (
        output wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
        input  wr_ready, rd_frame_valid, rd_data, rd_data_valid,
               wr_bank, rd_bank, frame_count, wr_overflow
    );
    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_last, rd_en, rd_addr, rd_done,
        output wr_ready, rd_frame_valid, rd_data, rd_data_valid,
               wr_bank, rd_bank, frame_count, wr_overflow
    );
`endif

endinterface

// File: rtl/dec_ram_bank.sv
// Single-port synchronous-read RAM for one frame bank; the read register
// resets to zero so the buffer's rd_data has a defined reset value.
module dec_ram_bank #(
    parameter int WIDTH      = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (cs && we)
            mem[addr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (cs && !we)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/dec_ram_pingpong.sv
// N-bank decision frame buffer between LDPC decoder and output stage.
// Optional macro DEC_RAM_PARITY_EN: per-word even parity and rd_parity_err.
module dec_ram_pingpong
    import dec_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
    parameter int NUM_BANKS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dec_ram_pingpong_if.slave bus
);

    localparam int BW = bank_idx_w(NUM_BANKS);
    localparam int CW = $clog2(NUM_BANKS + 1);
`ifdef DEC_RAM_PARITY_EN
    localparam int SW = DATA_WIDTH + 1;
`else
    localparam int SW = DATA_WIDTH;
`endif
    localparam logic [CW-1:0] FULL      = CW'(NUM_BANKS);
    localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

    if (NUM_BANKS < 2 || NUM_BANKS > MAX_BANKS) begin : g_bad_banks
        $error("dec_ram_pingpong: NUM_BANKS out of range 2..%0d", MAX_BANKS);
    end

    logic [BW-1:0] wr_ptr, rd_ptr, rd_sel;
    logic [CW-1:0] count;
    logic          ovf, rvld;
    logic          wr_ready, rd_frame_valid;
    logic          wr_acc, commit, rd_acc, release_bank;
    logic [SW-1:0] wdata_s;
    logic [SW-1:0] rd_word;
    logic [NUM_BANKS-1:0][SW-1:0] bank_q;

    assign wr_ready       = count < FULL;
    assign rd_frame_valid = count != '0;
    assign wr_acc         = bus.wr_valid && wr_ready;
    assign commit         = wr_acc && bus.wr_last;
    assign rd_acc         = bus.rd_en && rd_frame_valid;
    assign release_bank   = bus.rd_done && rd_frame_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_sel <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            rvld   <= 1'b0;
        end else begin
            if (commit)
                wr_ptr <= (wr_ptr == LAST_BANK) ? '0 : wr_ptr + 1'b1;
            if (release_bank)
                rd_ptr <= (rd_ptr == LAST_BANK) ? '0 : rd_ptr + 1'b1;
            // Commit and release together leave the count unchanged.
            case ({commit, release_bank})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (bus.wr_valid && !wr_ready)
                ovf <= 1'b1;
            rvld <= rd_acc;
            if (rd_acc)
                rd_sel <= rd_ptr;
        end
    end

`ifdef DEC_RAM_PARITY_EN
    assign wdata_s = {parity(MAX_DATA_W'(bus.wr_data)), bus.wr_data};
`else
    assign wdata_s = bus.wr_data;
`endif

    // wr_ptr == rd_ptr only when full or empty, so a bank never sees a read
    // and a write in the same cycle and one shared address port suffices.
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic                  we, cs;
        logic [ADDR_WIDTH-1:0] addr;

        assign we   = wr_acc && (wr_ptr == BW'(b));
        assign cs   = we || (rd_acc && (rd_ptr == BW'(b)));
        assign addr = we ? bus.wr_addr : bus.rd_addr;

        dec_ram_bank #(
            .WIDTH      (SW),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (RAM_DEPTH)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .cs    (cs),
            .we    (we),
            .addr  (addr),
            .wdata (wdata_s),
            .rdata (bank_q[b])
        );
    end

    assign rd_word            = bank_q[rd_sel];
    assign bus.rd_data        = rd_word[DATA_WIDTH-1:0];
    assign bus.rd_data_valid  = rvld;
    assign bus.wr_ready       = wr_ready;
    assign bus.rd_frame_valid = rd_frame_valid;
    assign bus.wr_bank        = wr_ptr;
    assign bus.rd_bank        = rd_ptr;
    assign bus.frame_count    = count;
    assign bus.wr_overflow    = ovf;

`ifdef DEC_RAM_PARITY_EN
    assign bus.rd_parity_err = rvld &&
        (parity(MAX_DATA_W'(rd_word[DATA_WIDTH-1:0])) != rd_word[DATA_WIDTH]);
`endif

    a_wr_addr: assert property (@(posedge clk) disable iff (!rst_n)
        bus.wr_valid |-> (32'(bus.wr_addr) < RAM_DEPTH));
    a_rd_addr: assert property (@(posedge clk) disable iff (!rst_n)
        bus.rd_en |-> (32'(bus.rd_addr) < RAM_DEPTH));

endmodule

// File: tb/tb_dec_ram_pingpong.sv
// Directed + random bench for dec_ram_pingpong against a frame-queue model.
module tb_dec_ram_pingpong;

    localparam int DW    = 4;
    localparam int AW    = 8;
    localparam int NB    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dec_ram_pingpong_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BANKS(NB)) bus ();

    dec_ram_pingpong #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .NUM_BANKS  (NB)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Model: banks as arrays, pointers as frame counters modulo NB.
    logic [DW-1:0] mem_m [NB][DEPTH];
    bit            bad_m [NB][DEPTH];
    int            wp, rp, cnt;
    bit            ovf_m, exp_vld, exp_perr;
    logic [DW-1:0] exp_data;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("rd_data_valid", 32'(bus.rd_data_valid), 32'(exp_vld));
        chk("rd_data", 32'(bus.rd_data), 32'(exp_data));
        chk("frame_count", 32'(bus.frame_count), 32'(cnt));
        chk("wr_bank", 32'(bus.wr_bank), 32'(wp));
        chk("rd_bank", 32'(bus.rd_bank), 32'(rp));
        chk("wr_ready", 32'(bus.wr_ready), 32'(cnt < NB));
        chk("rd_frame_valid", 32'(bus.rd_frame_valid), 32'(cnt != 0));
        chk("wr_overflow", 32'(bus.wr_overflow), 32'(ovf_m));
`ifdef DEC_RAM_PARITY_EN
        chk("rd_parity_err", 32'(bus.rd_parity_err), 32'(exp_vld && exp_perr));
`endif
    endtask

    task automatic model_reset();
        wp = 0; rp = 0; cnt = 0;
        ovf_m = 0; exp_vld = 0; exp_perr = 0; exp_data = '0;
    endtask

    task automatic idle();
        bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_last = 0;
        bus.rd_en = 0; bus.rd_addr = '0; bus.rd_done = 0;
    endtask

    // One clock: predict from the driven inputs, clock, then compare.
    task automatic tick();
        bit wa, cm, ra, rl;
        wa = bus.wr_valid && (cnt < NB);
        cm = wa && bus.wr_last;
        ra = bus.rd_en && (cnt != 0);
        rl = bus.rd_done && (cnt != 0);
        exp_vld = ra;
        exp_perr = 0;
        if (ra) begin
            exp_data = mem_m[rp][bus.rd_addr];
            exp_perr = bad_m[rp][bus.rd_addr];
        end
        if (wa) begin
            mem_m[wp][bus.wr_addr] = bus.wr_data;
            bad_m[wp][bus.wr_addr] = 0;
        end
        if (bus.wr_valid && !wa) ovf_m = 1;
        if (cm) wp = (wp + 1) % NB;
        if (rl) rp = (rp + 1) % NB;
        cnt = cnt + int'(cm) - int'(rl);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Writes every address once; pattern=1 uses data=addr[0] in order.
    task automatic wr_frame(input bit pattern, input bit done_last);
        int order[DEPTH];
        int j, t;
        for (int i = 0; i < DEPTH; i++) order[i] = i;
        if (!pattern)
            for (int i = DEPTH - 1; i > 0; i--) begin
                j = int'($urandom_range(i, 0));
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        for (int i = 0; i < DEPTH; i++) begin
            bus.wr_valid = 1;
            bus.wr_addr  = AW'(order[i]);
            bus.wr_data  = pattern ? DW'(order[i] & 1) : DW'($urandom);
            bus.wr_last  = (i == DEPTH - 1);
            bus.rd_done  = done_last && (i == DEPTH - 1);
            tick();
        end
        idle();
    endtask

    task automatic rd_addr_once(input int a);
        bus.rd_en = 1;
        bus.rd_addr = AW'(a);
        tick();
        idle();
    endtask

    task automatic release_frame();
        bus.rd_done = 1;
        tick();
        idle();
    endtask

    initial begin
        int a5;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        check_all();

        // Empty: reads and releases are ignored.
        bus.rd_en = 1; bus.rd_done = 1; bus.rd_addr = 8'd7;
        tick();
        tick();
        idle();

        // Basic frame.
        wr_frame(1, 0);
        chk("basic_count", 32'(bus.frame_count), 1);
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_en = 1;
            bus.rd_addr = AW'(a);
            tick();
        end
        idle();
        release_frame();
        chk("basic_wr_bank", 32'(bus.wr_bank), 1);
        chk("basic_rd_bank", 32'(bus.rd_bank), 1);

        // Fill to full, then a refused write.
        for (int f = 0; f < NB; f++) wr_frame(0, 0);
        chk("full_ready", 32'(bus.wr_ready), 0);
        chk("full_count", 32'(bus.frame_count), NB);
        a5 = int'($urandom_range(DEPTH - 1, 0));
        bus.wr_valid = 1; bus.wr_addr = AW'(a5); bus.wr_data = ~mem_m[wp][a5];
        tick();
        idle();
        chk("ovf_set", 32'(bus.wr_overflow), 1);
        rd_addr_once(a5);
        for (int k = 0; k < 8; k++) rd_addr_once(int'($urandom_range(DEPTH - 1, 0)));

        // Full boundary: commit refused, release accepted.
        bus.wr_valid = 1; bus.wr_last = 1; bus.wr_addr = 8'd3; bus.wr_data = 4'h5;
        bus.rd_done = 1;
        tick();
        idle();
        chk("bnd_count", 32'(bus.frame_count), NB - 1);
        chk("bnd_ready", 32'(bus.wr_ready), 1);

        // Commit and release together at count 2.
        release_frame();
        chk("cr_pre_count", 32'(bus.frame_count), 2);
        wr_frame(0, 1);
        chk("cr_count", 32'(bus.frame_count), 2);

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            bus.wr_valid = 1'($urandom_range(1, 0));
            bus.wr_addr  = AW'($urandom);
            bus.wr_data  = DW'($urandom);
            bus.wr_last  = bus.wr_valid && ($urandom_range(15, 0) == 0);
            bus.rd_en    = 1'($urandom_range(1, 0));
            bus.rd_addr  = AW'($urandom);
            bus.rd_done  = ($urandom_range(19, 0) == 0);
            tick();
        end
        idle();

        // Reset mid-frame with a read in flight.
        if (cnt == 0) begin
            bus.wr_valid = 1; bus.wr_last = 1; bus.wr_addr = 8'd9; bus.wr_data = 4'hA;
            tick();
            idle();
        end
        for (int k = 0; k < 5; k++) begin
            bus.wr_valid = 1; bus.wr_addr = AW'($urandom); bus.wr_data = DW'($urandom);
            bus.rd_en = 1; bus.rd_addr = AW'($urandom);
            tick();
        end
        idle();
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("rst_rd_data_valid", 32'(bus.rd_data_valid), 0);
        chk("rst_rd_data", 32'(bus.rd_data), 0);
        chk("rst_frame_count", 32'(bus.frame_count), 0);
        chk("rst_wr_bank", 32'(bus.wr_bank), 0);
        chk("rst_rd_bank", 32'(bus.rd_bank), 0);
        chk("rst_wr_overflow", 32'(bus.wr_overflow), 0);
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        check_all();

`ifdef DEC_RAM_PARITY_EN
        // Corrupt one stored word of bank 0; only that read flags an error.
        wr_frame(0, 0);
        dut.g_bank[0].u_bank.mem[10][0] = ~dut.g_bank[0].u_bank.mem[10][0];
        mem_m[0][10][0] = ~mem_m[0][10][0];
        bad_m[0][10] = 1;
        rd_addr_once(10);
        chk("perr_hit", 32'(bus.rd_parity_err), 1);
        rd_addr_once(11);
        chk("perr_clean", 32'(bus.rd_parity_err), 0);
        release_frame();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dec_ram_pingpong.md
Name: dec_ram_pingpong

Overview:
- N-bank frame buffer for hard-decision bits between the LDPC decoder core and the output stage.
- Decoder writes one frame of decisions into the current write bank, at any address order. It then commits the bank with wr_last.
- Output stage drains committed banks in commit order and releases each one with rd_done.
- Generalises the fixed two-bank decision RAM to NUM_BANKS banks, with bank rotation, full/empty handshake and overflow detection.

Parameters:
- DATA_WIDTH, 1, bits per decision word.
- ADDR_WIDTH, 8, word address width per bank.
- RAM_DEPTH, 1<<ADDR_WIDTH, words per bank.
- NUM_BANKS, 2, number of frame banks; legal range 2..16.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_valid  in  1  write strobe.
- wr_addr  in  ADDR_WIDTH  write address within the current write bank.
- wr_data  in  DATA_WIDTH  decision word.
- wr_last  in  1  qualifies wr_valid; commits the current write bank after this word.
- wr_ready  out  1  a free bank is available for writing.
- rd_en  in  1  read strobe.
- rd_addr  in  ADDR_WIDTH  read address within the current read bank.
- rd_done  in  1  releases the current read bank.
- rd_frame_valid  out  1  at least one committed bank is waiting.
- rd_data  out  DATA_WIDTH  read data.
- rd_data_valid  out  1  rd_data valid this cycle.
- wr_bank  out  $clog2(NUM_BANKS)  current write bank index.
- rd_bank  out  $clog2(NUM_BANKS)  current read bank index.
- frame_count  out  $clog2(NUM_BANKS+1)  number of committed, unreleased banks.
- wr_overflow  out  1  sticky: a write was attempted while wr_ready=0.

Behaviour:
- Reset (async assert, sync release) sets wr_bank=0, rd_bank=0, frame_count=0, wr_overflow=0, rd_data_valid=0 and rd_data=0. RAM contents are not cleared.
- Combinational flags from registered state:
  - wr_ready = (frame_count < NUM_BANKS).
  - rd_frame_valid = (frame_count != 0).
- Write accept: wr_valid & wr_ready writes wr_data to bank[wr_bank][wr_addr] at the clock edge.
- Commit: accepted write with wr_last=1 stores the word, then wr_bank increments modulo NUM_BANKS and frame_count increments.
- Refused write: wr_valid & !wr_ready drops the data, leaves pointers unchanged and sets wr_overflow. wr_overflow clears only on reset.
- Read: rd_en & rd_frame_valid reads bank[rd_bank][rd_addr]. rd_data and rd_data_valid are registered, latency exactly 1 cycle. When no read is issued, rd_data_valid=0 and rd_data holds its last value.
- Ignored read: rd_en with rd_frame_valid=0 does nothing.
- Release: rd_done & rd_frame_valid increments rd_bank modulo NUM_BANKS and decrements frame_count. rd_done while empty is ignored.
- Read then release in one cycle: rd_en and rd_done together is legal. The read uses the old rd_bank; data appears next cycle.
- Commit and release in one cycle: frame_count is unchanged and both pointers advance. This holds at frame_count=NUM_BANKS, where the release frees a bank and wr_ready rises next cycle; the same-cycle write is refused because wr_ready was 0.
- Collision freedom: wr_bank==rd_bank only when frame_count is 0 (read blocked) or NUM_BANKS (write blocked), so no same-bank read/write arbitration is needed.
- Address range: addresses >= RAM_DEPTH are unsupported; behaviour is undefined and the assertion checker flags them.
- Reset mid-frame: a partially written bank is discarded and all frames are lost.

Optional Feature:
- Macro: DEC_RAM_PARITY_EN.
- Enabled:
  - Each bank stores DATA_WIDTH+1 bits; the extra bit is the even parity of wr_data.
  - On read, parity is recomputed and output rd_parity_err (1 bit) is driven aligned with rd_data_valid.
  - rd_parity_err resets to 0.
- Disabled: the port is absent, the extra storage bit is not implemented and there is no parity logic.

Decomposition:
- Package dec_ram_pkg:
  - function bank_idx_w(n) returning $clog2(n).
  - parity function.
  - localparam MAX_BANKS=16.
- Sub-module dec_ram_bank: single-port, synchronous-read RAM of DEPTH x WIDTH with we/cs. It is instantiated NUM_BANKS times in a generate loop, with write and read chip-select steered by wr_bank and rd_bank.
- Pointer, count and overflow logic stays in the top level.

Test Plan:
- Basic frame: write addrs 0..255 data=addr[0], last at 255, then read 0..255 and rd_done. rd_data matches, with rd_data_valid 1 cycle after each rd_en; frame_count goes 0->1->0; wr_bank=1, rd_bank=1.
- Fill to full: NUM_BANKS=4, commit 4 frames. wr_ready=0 and frame_count=4; a 5th write sets wr_overflow=1 and leaves bank contents unchanged.
- Commit and release together: at frame_count=2 of 4, assert wr_last and rd_done in the same cycle. frame_count stays 2 and both pointers advance by 1.
- Full-boundary release: at frame_count=4 of 4, wr_valid+wr_last and rd_done in the same cycle. The write is dropped, wr_overflow=1, frame_count=3 and wr_ready=1 next cycle.
- Empty and reset: rd_en/rd_done with frame_count=0 give no rd_data_valid and no pointer change. rst_n asserted mid-frame returns all outputs to reset values asynchronously.
- DEC_RAM_PARITY_EN: force a stored bit flip through a hierarchical path. rd_parity_err=1 is raised on that read only.
